uart_tx_serializer: RTL and testbench

- Transmit-side serializer between the TX FIFO read port and the UART TX pin.
- Pops 16-bit words from the TX FIFO and sends each word as two 8N1 UART frames: high byte first, bits LSB-first.
- Bit period is taken from the SPI-programmed baud divisor.
- Instantiated inside the UART controller; it drives the FIFO read enable and the serial line.

---
 rtl/uart_tx_serializer.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// Serializes 16-bit TX FIFO words into two back-to-back UART frames, high byte first, LSB-first bits.
// Optional even-parity bit after each data byte when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DIV_W-1:0]  baud_divisor,
    output logic              tx,
    output logic              busy
);

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic [DIV_W-1:0]       period_q, period_d;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic                   byte_idx_q, byte_idx_d;
    logic                   tx_q, tx_d;
    logic                   fifo_rd_en_c;
    logic                   busy_c;
    logic                   bit_done;
    logic [DIV_W-1:0]       cnt_reload;
    logic [BYTE_W-1:0]      byte_d;

    function automatic logic [BYTE_W-1:0] sel_byte(input logic [DATA_W-1:0] h, input logic idx);
        return idx ? h[BYTE_W-1:0] : h[DATA_W-1 -: BYTE_W];
    endfunction

    // State and datapath registers; tx idles high and returns high at once on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            period_q   <= '0;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            tx_q       <= tx_d;
        end
    end

    // Next-state, counters and next tx level
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        period_d     = period_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        fifo_rd_en_c = 1'b0;
        tx_d         = 1'b1;
        bit_done     = (cnt_q == '0);
        cnt_reload   = period_q - DIV_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd_en_c = 1'b1;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                hold_d     = fifo_data;
                period_d   = (baud_divisor == '0) ? DIV_W'(1) : baud_divisor;
                cnt_d      = period_d - DIV_W'(1);
                bit_idx_d  = '0;
                byte_idx_d = 1'b0;
                state_d    = ST_START;
            end
            ST_START: begin
                if (bit_done) begin
                    cnt_d     = cnt_reload;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_d = cnt_reload;
                    if (bit_idx_q == BIT_IDX_W'(BYTE_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    cnt_d   = cnt_reload;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    cnt_d = cnt_reload;
                    if (!byte_idx_q) begin
                        byte_idx_d = 1'b1;
                        state_d    = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // tx is registered, so it is derived from where the FSM goes next
        byte_d = sel_byte(hold_d, byte_idx_d);
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = byte_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = ^byte_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // The pop strobe must coincide with the IDLE decision cycle so data is ready in WAIT
    assign busy_c     = (state_q != ST_IDLE) | (fifo_rd_en_c & rst_n);
    assign fifo_rd_en = fifo_rd_en_c & rst_n;
    assign busy       = busy_c;
    assign tx         = tx_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: table of single words plus multi-word and reset sequences.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int TR_MAX = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] fifo_data = 16'h0000;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] baud_divisor = 16'd4;
    logic        tx;
    logic        busy;

    uart_tx_serializer #(.DATA_W(16), .DIV_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .baud_divisor (baud_divisor),
        .tx           (tx),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // FIFO model: write pointer owned by the stimulus, read pointer by the pop logic
    logic [15:0] fmem [16];
    logic [3:0]  wp = 4'd0;
    logic [3:0]  rp = 4'd0;
    int          underflows = 0;
    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_empty) underflows <= underflows + 1;
            else begin
                fifo_data <= fmem[rp];
                rp        <= rp + 4'd1;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        fmem[wp] = w;
        wp = wp + 4'd1;
    endtask

    // Expected waveform built from hand-written bytes
    logic exp_tx [TR_MAX];
    int   exp_len, exp_busy, exp_rd;

    task automatic exp_clear();
        exp_len = 0; exp_busy = 0; exp_rd = 0;
        for (int i = 0; i < TR_MAX; i++) exp_tx[i] = 1'b1;
    endtask

    task automatic exp_frame(input logic [7:0] b, input logic par, input int per);
        logic bits [11];
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        bits[9]  = par;
        bits[10] = 1'b1;
`else
        bits[9]  = 1'b1;
        bits[10] = par;
`endif
        for (int j = 0; j < FRAME_BITS; j++)
            for (int p = 0; p < per; p++) begin
                exp_tx[exp_len] = bits[j];
                exp_len++;
            end
    endtask

    task automatic exp_word(input logic [7:0] hi, input logic [7:0] lo,
                            input logic ph, input logic pl, input int per);
        exp_tx[exp_len] = 1'b1; exp_tx[exp_len+1] = 1'b1;
        exp_len += 2;
        exp_frame(hi, ph, per);
        exp_frame(lo, pl, per);
        exp_busy += 2 + 2 * FRAME_BITS * per;
        exp_rd++;
    endtask

    // Captured trace, one sample per cycle taken 1ns after the falling edge
    logic tr_tx [TR_MAX];
    logic tr_busy [TR_MAX];
    logic tr_rd [TR_MAX];

    task automatic record(input int n, input int chg_at, input logic [15:0] chg_val);
        #1;
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            if (c == chg_at) baud_divisor = chg_val;
            tr_tx[c] = tx; tr_busy[c] = busy; tr_rd[c] = fifo_rd_en;
        end
    endtask

    task automatic check_trace(input string name, input int n);
        int bad = -1;
        int nb = 0;
        int nr = 0;
        for (int c = 0; c < n; c++) begin
            if (bad < 0 && tr_tx[c] !== exp_tx[c]) bad = c;
            if (tr_busy[c] === 1'b1) nb++;
            if (tr_rd[c] === 1'b1) nr++;
        end
        chk({name, " tx first mismatch cycle"}, bad, -1);
        chk({name, " busy cycles"}, nb, exp_busy);
        chk({name, " rd_en pulses"}, nr, exp_rd);
    endtask

    typedef struct {
        logic [15:0] word;
        logic [15:0] div;
        int          per;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic        par_hi;
        logic        par_lo;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;
        int gap;
        int end1;

        vecs[0] = '{16'hA55A, 16'd4, 4, 8'hA5, 8'h5A, 1'b0, 1'b0};
        vecs[1] = '{16'h00FF, 16'd0, 1, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{16'h0001, 16'd2, 2, 8'h00, 8'h01, 1'b0, 1'b1};
        vecs[3] = '{16'hFFFF, 16'd2, 2, 8'hFF, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{16'h0301, 16'd1, 1, 8'h03, 8'h01, 1'b0, 1'b1};
        vecs[5] = '{16'h1234, 16'd3, 3, 8'h12, 8'h34, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        #1;
        chk("reset tx", int'(tx), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset rd_en", int'(fifo_rd_en), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("idle empty rd_en", int'(fifo_rd_en), 0);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            baud_divisor = vecs[i].div;
            push(vecs[i].word);
            exp_clear();
            exp_word(vecs[i].hi, vecs[i].lo, vecs[i].par_hi, vecs[i].par_lo, vecs[i].per);
            n = exp_len + 3;
            record(n, -1, 16'd0);
            check_trace($sformatf("vec%0d", i), n);
        end

        // Back-to-back words: two idle-high cycles between them
        @(negedge clk);
        baud_divisor = 16'd2;
        push(16'h0001);
        push(16'hFFFF);
        exp_clear();
        exp_word(8'h00, 8'h01, 1'b0, 1'b1, 2);
        exp_word(8'hFF, 8'hFF, 1'b0, 1'b0, 2);
        n = exp_len + 3;
        record(n, -1, 16'd0);
        check_trace("b2b", n);
        end1 = 2 + 4 * FRAME_BITS;
        gap = 0;
        while (end1 + gap < n && tr_tx[end1 + gap] === 1'b1) gap++;
        chk("b2b inter-word gap", gap, 2);

        // Divisor rewritten mid-word only affects the following word
        @(negedge clk);
        baud_divisor = 16'd8;
        push(16'h1234);
        push(16'h00FF);
        exp_clear();
        exp_word(8'h12, 8'h34, 1'b0, 1'b1, 8);
        exp_word(8'h00, 8'hFF, 1'b0, 1'b0, 3);
        n = exp_len + 3;
        record(n, 20, 16'd3);
        check_trace("divchg", n);

        // Reset in the middle of DATA drops 0xBEEF; the next queued word follows
        @(negedge clk);
        baud_divisor = 16'd2;
        push(16'hBEEF);
        push(16'h1111);
        repeat (9) @(negedge clk);
        #1;
        chk("pre-reset busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("async reset tx", int'(tx), 1);
        chk("async reset busy", int'(busy), 0);
        chk("reset rd_en with data", int'(fifo_rd_en), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_clear();
        exp_word(8'h11, 8'h11, 1'b0, 1'b0, 2);
        n = exp_len + 3;
        record(n, -1, 16'd0);
        chk("rd_en first cycle after release", int'(tr_rd[0]), 1);
        check_trace("post-reset", n);

        @(negedge clk);
        chk("fifo drained", int'(wp == rp), 1);
        chk("underflows", underflows, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
